// File: rtl/dmem_bus_pkg.sv
// Shared types and constants for the data-memory bus controller:
// FSM states, decode results and MMIO register offsets.
package dmem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } bus_state_t;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_FAULT
  } dec_t;

  localparam logic [7:0] OFF_GPIO_OUT = 8'h00;
  localparam logic [7:0] OFF_GPIO_IN  = 8'h02;
  localparam logic [7:0] OFF_CYCLE    = 8'h04;
  localparam logic [7:0] OFF_STATUS   = 8'h06;

endpackage

// File: rtl/dmem_array.sv
// Word-indexed data RAM: synchronous write, combinational read.
module dmem_array #(
  parameter int n     = 16,
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [n-1:0]  wdata,
  output logic [n-1:0]  rdata
);

  logic [n-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; clearing every word would turn
  // the array into flops and software never relies on power-up contents.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_bus_ctrl.sv
// CPU data-port controller: RAM with wait states, MMIO window (GPIO, cycle
// counter, status) and a sticky error flag for bad accesses.
module dmem_bus_ctrl
  import dmem_bus_pkg::*;
#(
  parameter int           n         = 16,
  parameter int           DEPTH     = 128,
  parameter int           WAIT      = 2,
  parameter logic [n-1:0] MMIO_BASE = 16'hFF00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  input  logic         we,
  input  logic [n-1:0] adr,
  input  logic [n-1:0] wdata,
  output logic [n-1:0] rdata,
  output logic         stall,
  output logic         done,
  output logic         err,
  output logic [n-1:0] gpio_out,
  input  logic [n-1:0] gpio_in
);

  localparam int AW = $clog2(DEPTH);

  bus_state_t   state, state_nx;
  dec_t         dec;
  logic [3:0]   wcnt;
  logic [n-1:0] cycle;
  logic [n-1:0] word_idx;
  logic [n-1:0] ram_rd;
  logic [n-1:0] mmio_rd;
  logic [7:0]   off;
  logic         commit, ram_we, cyc_clr, err_set, err_clr;

  assign word_idx = {1'b0, adr[n-1:1]};
  assign off      = adr[7:0];

  // NOTE: every combinational output gets a default first, so no path through
  // the branches can leave it unassigned and infer a latch.
  always_comb begin
    dec = DEC_RAM;
    if (adr[0])                                 dec = DEC_FAULT;
    else if (adr[n-1:8] == MMIO_BASE[n-1:8])    dec = DEC_MMIO;
    else if (word_idx >= n'(DEPTH))             dec = DEC_FAULT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req) state_nx = (dec == DEC_RAM && WAIT != 0) ? BUSY : DONE;
      BUSY:    if (wcnt == 4'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall = (state == IDLE && req) || state == BUSY;
    done  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset)              wcnt <= '0;
    else if (state == IDLE) wcnt <= 4'(WAIT);
    else if (state == BUSY) wcnt <= wcnt - 4'd1;
  end

  // All side effects land on the edge that enters DONE; reset suppresses them.
  assign commit  = state_nx == DONE && state != DONE && !reset;
  assign ram_we  = commit && dec == DEC_RAM && we;
  assign cyc_clr = commit && dec == DEC_MMIO && we && off == OFF_CYCLE;
  assign err_set = commit && dec == DEC_FAULT;
  assign err_clr = commit && dec == DEC_MMIO && we && off == OFF_STATUS && wdata[0];

  dmem_array #(.n(n), .DEPTH(DEPTH), .AW(AW)) u_array (
    .clk  (clk),
    .we   (ram_we),
    .idx  (adr[AW:1]),
    .wdata(wdata),
    .rdata(ram_rd)
  );

  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_GPIO_OUT: mmio_rd = gpio_out;
      OFF_GPIO_IN:  mmio_rd = gpio_in;
      OFF_CYCLE:    mmio_rd = cycle;
      OFF_STATUS:   mmio_rd = {{(n-1){1'b0}}, err};
      default:      mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata    <= '0;
      gpio_out <= '0;
      cycle    <= '0;
      err      <= 1'b0;
    end else begin
      cycle <= cyc_clr ? '0 : cycle + n'(1);
      err   <= err_set | (err & ~err_clr);
      if (commit) begin
        case (dec)
          DEC_FAULT: rdata <= '0;
          DEC_MMIO: begin
            if (!we)                     rdata    <= mmio_rd;
            else if (off == OFF_GPIO_OUT) gpio_out <= wdata;
          end
          default:   if (!we) rdata <= ram_rd;
        endcase
      end
    end
  end

endmodule

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

Parametrised data-memory subsystem between the CPU data port and main memory, replacing the single-cycle `dmem` hookup in `computer`. It adds an internal word RAM with configurable wait states and a stall/done handshake to the CPU. It also decodes a memory-mapped I/O window (GPIO out/in, free-running cycle counter, status) and flags misaligned or out-of-range accesses with a sticky error bit. Instantiated once per computer, beside `imem`.

## Interface
- `n`, 16: data and byte-address width.
- `DEPTH`, 128: RAM depth in n-bit words.
- `WAIT`, 2: extra wait cycles per RAM access, 0..15.
- `MMIO_BASE`, 16'hFF00: MMIO window base. Only bits [n-1:8] are significant; the window is 256 bytes.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: CPU access request. Held with `we`/`adr`/`wdata` stable while `stall`=1.
- `we` in 1: 1 = write, 0 = read.
- `adr` in n: byte address, 2-byte aligned.
- `wdata` in n: write data.
- `rdata` out n: read data, registered, valid when `done`=1, held until next completion.
- `stall` out 1: CPU must freeze.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky fault flag.
- `gpio_out` out n: MMIO output register.
- `gpio_in` in n: external input, sampled on MMIO read.

## Operation
- FSM states:
  - IDLE: accepts `req`. Goes to BUSY (RAM, WAIT>0) or DONE (RAM with WAIT=0, MMIO, fault). Counter loaded with WAIT.
  - BUSY: counter decrements each cycle. Goes to DONE on the edge where the counter reaches 1.
  - DONE: `done`=1. Always returns to IDLE, so a `req` seen in DONE is not accepted.
- `stall` (combinational) = (IDLE & `req`) | BUSY. `stall`=0 in DONE.
- Effects commit on the edge entering DONE: RAM/MMIO write, `rdata` load, `err` set.
- Decode, in priority order:
  - `adr[0]`=1 → fault.
  - `adr[n-1:8]`==`MMIO_BASE[n-1:8]` → MMIO.
  - Word index `adr[n-1:1]` ≥ DEPTH → fault.
  - Otherwise RAM.
- Fault behaviour: `err` is set, `rdata` = 0, the write is dropped, and latency is 1 like MMIO.
- MMIO offsets:
  - +0: `gpio_out`, R/W.
  - +2: `gpio_in`, R; writes are ignored.
  - +4: cycle counter. Read returns its value. Write clears it to 0; the clear beats that cycle's increment.
  - +6: status. bit0 = `err`, upper bits 0. Writing with `wdata[0]`=1 clears `err`.
  - Other offsets: read 0, write ignored, no fault.
- Cycle counter: n-bit, +1 every clock not in reset, wraps from all-ones to 0.
- `err` set and clear on the same edge: set wins.

## Timing
- Reset values: state IDLE, `rdata`=0, `done`=0, `stall`=`req`, `err`=0, `gpio_out`=0, cycle counter=0. RAM contents are not reset.
- RAM access: `req` at cycle 0 → `done` at cycle WAIT+1. MMIO or fault: `done` at cycle 1.
- Back-to-back: the next request is accepted no earlier than 1 cycle after DONE. Throughput is WAIT+2 cycles per RAM access.
- Reset during BUSY: the access aborts, no write commits, and no `done` pulse is issued.
- Read-after-write to the same word returns the new data.

## Structure
- Package `dmem_bus_pkg`:
  - state enum `bus_state_t` {IDLE, BUSY, DONE}
  - MMIO offset localparams `OFF_GPIO_OUT`, `OFF_GPIO_IN`, `OFF_CYCLE`, `OFF_STATUS`
  - decode-result enum {DEC_RAM, DEC_MMIO, DEC_FAULT}
- Sub-module `dmem_array`: DEPTH×n storage, synchronous write, combinational read, word-indexed.
- Top file holds the FSM, wait counter, MMIO registers and decode.

## Test plan
- Reset, then RAM write 16'hBEEF to 0x0010, then read 0x0010 with WAIT=2 → `stall` high for cycles 0–2, `done` at cycle 3, `rdata`=16'hBEEF.
- WAIT=0: write then read 0x0002 back-to-back → each `done` arrives 1 cycle after its `req`, and a `req` held through DONE is not accepted until IDLE.
- Read 0x0003 (misaligned) → `done` at cycle 1, `rdata`=0, `err`=1 and stays set. Write 16'h0001 to 0xFF06 → `err`=0.
- Write 16'h00A5 to 0xFF00 → `gpio_out`=16'h00A5. Drive `gpio_in`=16'h1234 and read 0xFF02 → `rdata`=16'h1234.
- Read 0xFF04 twice, 10 cycles apart → difference 10. Write 0xFF04 → next read equals cycles elapsed since the clear. Preload near all-ones and check wrap to 0.
- Assert `reset` mid-BUSY during a write to 0x0020 → no `done`, later read of 0x0020 returns the old contents, all outputs at reset values.
